// File: rtl/layer0_input_packer_pkg.sv
// Shared definitions for the LUT-network input packers: frame geometry,
// default quantizer settings and the feature quantizer function.
package layer0_input_packer_pkg;

    localparam int N_FEAT     = 16;
    localparam int IN_W       = 8;
    localparam int Q_W        = 2;
    localparam int DEF_SHIFT  = 4;
    localparam int DEF_OFFSET = 2;

    localparam int VEC_W = N_FEAT * Q_W;
    localparam int IDX_W = $clog2(N_FEAT);
    localparam int Q_MAX = (1 << Q_W) - 1;

    // Arithmetic shift, signed offset, then clamp to the unsigned Q_W range.
    // One extra bit of headroom keeps the offset add from wrapping.
    function automatic logic [Q_W-1:0] quantize(
        input logic [IN_W-1:0] raw,
        input int              shift,
        input int              offset
    );
        logic signed [IN_W:0] t;
        t = ($signed({raw[IN_W-1], raw}) >>> shift) + $signed((IN_W+1)'(offset));
        if (t[IN_W]) begin
            return '0;
        end else if (t > $signed((IN_W+1)'(Q_MAX))) begin
            return Q_W'(Q_MAX);
        end else begin
            return t[Q_W-1:0];
        end
    endfunction

endpackage

// File: rtl/layer0_input_packer_if.sv
// Feature stream in, packed frame out, plus the framing error pulse.
interface layer0_input_packer_if;
    import layer0_input_packer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [VEC_W-1:0] out_vec;
    logic             frame_err;

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, frame_err
    );

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, frame_err
    );

endinterface

// File: rtl/layer0_input_packer_feature_quantizer.sv
// Combinational raw-feature to Q_W-bit quantizer.
module feature_quantizer
    import layer0_input_packer_pkg::*;
#(
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic [IN_W-1:0] raw,
    output logic [Q_W-1:0]  q
);

    // quantize the current beat
    always_comb begin
        q = quantize(raw, SHIFT, OFFSET);
    end

endmodule

// File: rtl/layer0_input_packer.sv
// Packs a frame of quantized features into a flat vector for the layer-0
// LUTs. Fill register collects the next frame while the output register
// holds the current one steady for the consumer.
module layer0_input_packer
    import layer0_input_packer_pkg::*;
#(
    parameter int SHIFT  = DEF_SHIFT,
    parameter int OFFSET = DEF_OFFSET
) (
    input  logic                  clk,
    input  logic                  rst,
    layer0_input_packer_if.slave  bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_FEAT - 1);

    logic [IDX_W-1:0] idx;
    logic [VEC_W-1:0] fill;
    logic [VEC_W-1:0] out_vec;
    logic             fill_full;
    logic             out_valid;
    logic             frame_err;
    logic [Q_W-1:0]   q;

    logic accept;
    logic at_last;
    logic beat_err;
    logic beat_done;
    logic xfer;

    feature_quantizer #(
        .SHIFT  (SHIFT),
        .OFFSET (OFFSET)
    ) u_quant (
        .raw (bus.in_data),
        .q   (q)
    );

    // beat acceptance, framing checks and fill-to-output transfer decode
    always_comb begin
        accept    = bus.in_valid && !rst && !fill_full;
        at_last   = (idx == LAST_IDX);
        beat_err  = accept && (bus.in_last != at_last);
        beat_done = accept && bus.in_last && at_last;
        xfer      = fill_full && (!out_valid || bus.out_ready);
    end

    assign bus.in_ready  = !rst && !fill_full;
    assign bus.out_valid = out_valid;
    assign bus.out_vec   = out_vec;
    assign bus.frame_err = frame_err;

    // fill/output double buffer; a bad frame just rewinds idx so its
    // partial contents get overwritten by the next frame
    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            fill      <= '0;
            fill_full <= 1'b0;
            out_vec   <= '0;
            out_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= beat_err;

            if (accept) begin
                fill[int'(idx) * Q_W +: Q_W] <= q;
                idx <= (beat_err || beat_done) ? '0 : idx + 1'b1;
            end

            if (beat_done) begin
                fill_full <= 1'b1;
            end else if (xfer) begin
                fill_full <= 1'b0;
            end

            if (xfer) begin
                out_vec   <= fill;
                out_valid <= 1'b1;
            end else if (out_valid && bus.out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_layer0_input_packer.sv
module tb_layer0_input_packer;
    import layer0_input_packer_pkg::*;

    typedef logic [IN_W-1:0] frame_t [N_FEAT];

    localparam int N_RAND_FRAMES = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests_run = 0;
    int   failed = 0;

    logic [VEC_W-1:0] exp_q [$];
    int               rx_count = 0;

    layer0_input_packer_if bus();

    layer0_input_packer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference quantizer: floor division by 2^SHIFT, add offset, clamp.
    function automatic int q_ref(input logic [IN_W-1:0] raw);
        int x, t, div;
        div = 1 << DEF_SHIFT;
        x = int'($signed(raw));
        if (x >= 0) t = x / div;
        else        t = -((-x + div - 1) / div);
        t = t + DEF_OFFSET;
        if (t < 0) t = 0;
        if (t > (1 << Q_W) - 1) t = (1 << Q_W) - 1;
        return t;
    endfunction

    function automatic logic [VEC_W-1:0] pack_ref(input frame_t f);
        logic [VEC_W-1:0] v;
        v = '0;
        for (int i = 0; i < N_FEAT; i++) v[i*Q_W +: Q_W] = Q_W'(q_ref(f[i]));
        return v;
    endfunction

    function automatic frame_t rand_frame();
        frame_t f;
        for (int i = 0; i < N_FEAT; i++) f[i] = IN_W'($urandom);
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last);
        int   n;
        logic acc;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        do begin
            acc = bus.in_ready;
            tick();
            n++;
        end while (!acc && n < 200);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        if (!acc) check("beat_accept_timeout", acc, 1);
    endtask

    task automatic send_frame(input frame_t f);
        for (int i = 0; i < N_FEAT; i++) send_beat(f[i], i == N_FEAT - 1);
    endtask

    task automatic wait_out(input string tag, input logic [VEC_W-1:0] exp);
        int n;
        n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, bus.out_valid, 1);
        check({tag, "_vec"}, bus.out_vec, exp);
    endtask

    initial begin
        frame_t fa, fb, fc;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_vec", bus.out_vec, 0);
        check("rst_frame_err", bus.frame_err, 0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", bus.in_ready, 1);

        // 1: constant 0x20 frame, latency of two cycles from last beat
        bus.out_ready = 1'b1;
        for (int i = 0; i < N_FEAT; i++) send_beat(8'h20, i == N_FEAT - 1);
        check("t1_valid_T1", bus.out_valid, 0);
        check("t1_in_ready_full", bus.in_ready, 0);
        tick();
        check("t1_valid_T2", bus.out_valid, 1);
        check("t1_vec", bus.out_vec, 32'hFFFF_FFFF);
        check("t1_in_ready_back", bus.in_ready, 1);
        tick();
        check("t1_consumed", bus.out_valid, 0);
        check("t1_vec_hold", bus.out_vec, 32'hFFFF_FFFF);

        // 2: saturation corners in slices 0..3
        fa = rand_frame();
        fa[0] = 8'h80; fa[1] = 8'hE0; fa[2] = 8'h00; fa[3] = 8'h7F;
        send_frame(fa);
        wait_out("t2", pack_ref(fa));
        check("t2_slices", bus.out_vec[7:0], 8'hE0);
        tick();

        // 3: backpressure with two frames
        bus.out_ready = 1'b0;
        fa = rand_frame();
        fb = rand_frame();
        send_frame(fa);
        send_frame(fb);
        check("t3_in_ready_low", bus.in_ready, 0);
        check("t3_hold_valid", bus.out_valid, 1);
        check("t3_hold_a", bus.out_vec, pack_ref(fa));
        repeat (3) tick();
        check("t3_hold_a_later", bus.out_vec, pack_ref(fa));
        check("t3_in_ready_still_low", bus.in_ready, 0);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check("t3_swap_valid", bus.out_valid, 1);
        check("t3_swap_b", bus.out_vec, pack_ref(fb));
        check("t3_in_ready_back", bus.in_ready, 1);
        bus.out_ready = 1'b1;
        tick();
        check("t3_drained", bus.out_valid, 0);

        // 4: early in_last, then a clean frame, then missing in_last
        for (int i = 0; i < 10; i++) send_beat(IN_W'($urandom), i == 9);
        check("t4_early_err", bus.frame_err, 1);
        check("t4_early_no_valid", bus.out_valid, 0);
        tick();
        check("t4_err_pulse_end", bus.frame_err, 0);
        fc = rand_frame();
        send_frame(fc);
        wait_out("t4_clean", pack_ref(fc));
        tick();
        for (int i = 0; i < N_FEAT; i++) send_beat(IN_W'($urandom), 1'b0);
        check("t4_missing_last_err", bus.frame_err, 1);
        tick();
        check("t4_missing_pulse_end", bus.frame_err, 0);
        repeat (3) tick();
        check("t4_dropped", bus.out_valid, 0);
        fc = rand_frame();
        send_frame(fc);
        wait_out("t4_clean2", pack_ref(fc));
        tick();

        // 5: reset mid-frame while a frame is pending at the output
        bus.out_ready = 1'b0;
        fa = rand_frame();
        send_frame(fa);
        wait_out("t5_pending", pack_ref(fa));
        for (int i = 0; i < 8; i++) send_beat(IN_W'($urandom), 1'b0);
        rst = 1'b1;
        tick();
        check("t5_rst_valid", bus.out_valid, 0);
        check("t5_rst_vec", bus.out_vec, 0);
        check("t5_rst_err", bus.frame_err, 0);
        check("t5_rst_in_ready", bus.in_ready, 0);
        rst = 1'b0;
        tick();
        check("t5_no_err_after", bus.frame_err, 0);
        bus.out_ready = 1'b1;
        fb = rand_frame();
        send_frame(fb);
        wait_out("t5_clean", pack_ref(fb));
        tick();

        // 6: random stalls on both sides against the reference queue
        fork
            begin
                frame_t fr;
                for (int f = 0; f < N_RAND_FRAMES; f++) begin
                    fr = rand_frame();
                    if ($urandom_range(3) == 0) fr[$urandom_range(N_FEAT-1)] = 8'h80;
                    if ($urandom_range(3) == 0) fr[$urandom_range(N_FEAT-1)] = 8'h7F;
                    exp_q.push_back(pack_ref(fr));
                    for (int i = 0; i < N_FEAT; i++) begin
                        if ($urandom_range(4) == 0) repeat ($urandom_range(2, 1)) tick();
                        send_beat(fr[i], i == N_FEAT - 1);
                    end
                end
            end
            begin
                logic             stall_prev;
                logic [VEC_W-1:0] vec_prev;
                logic [VEC_W-1:0] exp_v;
                int               cyc;
                stall_prev = 1'b0;
                vec_prev   = '0;
                cyc        = 0;
                while (rx_count < N_RAND_FRAMES && cyc < 60000) begin
                    tick();
                    cyc++;
                    if (stall_prev) begin
                        check("t6_stall_valid", bus.out_valid, 1);
                        check("t6_stall_vec", bus.out_vec, vec_prev);
                    end
                    bus.out_ready = ($urandom_range(3) != 0);
                    if (bus.out_valid && bus.out_ready) begin
                        check("t6_queue_nonempty", exp_q.size() > 0, 1);
                        exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                        check("t6_frame", bus.out_vec, exp_v);
                        rx_count++;
                    end
                    stall_prev = bus.out_valid && !bus.out_ready;
                    vec_prev   = bus.out_vec;
                end
                bus.out_ready = 1'b1;
            end
        join
        check("t6_rx_count", rx_count, N_RAND_FRAMES);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_no_err", bus.frame_err, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
